// File: rtl/amo_responder.sv
// Atomic-memory-operation responder: runs one LR/SC/AMO at a time as a
// read-modify-write on a single-ported 64-bit memory bus, keeps the LR/SC
// reservation and returns a one-cycle acknowledge with the old value.
module amo_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 amo_req_i,
  input  logic [3:0]           amo_op_i,
  input  logic [1:0]           amo_size_i,
  input  logic [AddrWidth-1:0] amo_operand_a_i,
  input  logic [DataWidth-1:0] amo_operand_b_i,
  output logic                 amo_ack_o,
  output logic [DataWidth-1:0] amo_result_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [7:0]           mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLr   = 4'd1;
  localparam logic [3:0] OpSc   = 4'd2;
  localparam logic [3:0] OpSwap = 4'd3;
  localparam logic [3:0] OpAdd  = 4'd4;
  localparam logic [3:0] OpAnd  = 4'd5;
  localparam logic [3:0] OpOr   = 4'd6;
  localparam logic [3:0] OpXor  = 4'd7;
  localparam logic [3:0] OpMax  = 4'd8;
  localparam logic [3:0] OpMaxu = 4'd9;
  localparam logic [3:0] OpMin  = 4'd10;
  localparam logic [3:0] OpMinu = 4'd11;

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StScCheck, StWrReq, StWrWait, StAck
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             op_q;
  logic                   dbl_q;
  logic [AddrWidth-1:2]   addr_q;
  logic [DataWidth-1:0]   opb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [DataWidth-1:0]   result_q;
  logic                   res_valid_q;
  logic [AddrWidth-1:3]   res_line_q;
  logic                   res_half_q;
  logic                   res_dbl_q;

  logic                   accept;
  logic                   legal;
  logic                   sc_match;
  logic [31:0]            half_old;
  logic [31:0]            rd_half;
  logic [DataWidth-1:0]   old_u, old_s, opb_u, opb_s, alu;
  logic [DataWidth-1:0]   wdata;
  logic [7:0]             be;
  logic                   unused_addr_lsb;

  // Word ops ignore the byte offset within the 32-bit half.
  assign unused_addr_lsb = ^amo_operand_a_i[1:0];

  assign accept   = (state_q == StIdle) && amo_req_i;
  // Unknown op encodings are treated like an illegal size: acked with 0.
  assign legal    = amo_size_i[1] && (amo_op_i != OpNone) && (amo_op_i <= OpMinu);
  // SC must hit the same line, the same half and the same size as the LR.
  assign sc_match = res_valid_q && (res_line_q == addr_q[AddrWidth-1:3]) &&
                    (res_half_q == addr_q[2]) && (res_dbl_q == dbl_q);
  assign half_old = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign rd_half  = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
  assign be       = dbl_q ? 8'hFF : (addr_q[2] ? 8'hF0 : 8'h0F);

  // Modify step: word ops extend both operands so one 64-bit datapath serves both sizes.
  always_comb begin
    old_u = dbl_q ? rdata_q : {32'b0, half_old};
    old_s = dbl_q ? rdata_q : {{32{half_old[31]}}, half_old};
    opb_u = dbl_q ? opb_q : {32'b0, opb_q[31:0]};
    opb_s = dbl_q ? opb_q : {{32{opb_q[31]}}, opb_q[31:0]};
    alu   = opb_u;
    case (op_q)
      OpAdd:  alu = old_u + opb_u;
      OpAnd:  alu = old_u & opb_u;
      OpOr:   alu = old_u | opb_u;
      OpXor:  alu = old_u ^ opb_u;
      OpMax:  alu = ($signed(old_s) < $signed(opb_s)) ? opb_u : old_u;
      OpMaxu: alu = (old_u < opb_u) ? opb_u : old_u;
      OpMin:  alu = ($signed(old_s) < $signed(opb_s)) ? old_u : opb_u;
      OpMinu: alu = (old_u < opb_u) ? old_u : opb_u;
      default: alu = opb_u; // SWAP and SC store operand b
    endcase
    // Word results are replicated; the byte enables pick the live half.
    wdata = dbl_q ? alu : {alu[31:0], alu[31:0]};
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state and all outputs, decoded from the current state only.
  always_comb begin
    state_d      = state_q;
    amo_ack_o    = 1'b0;
    amo_result_o = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    unique case (state_q)
      StIdle: begin
        if (amo_req_i) begin
          if (!legal)                state_d = StAck;
          else if (amo_op_i == OpSc) state_d = StScCheck;
          else                       state_d = StRdReq;
        end
      end
      StRdReq: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[AddrWidth-1:3], 3'b000};
        mem_be_o   = be;
        if (mem_gnt_i) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_rvalid_i) state_d = (op_q == OpLr) ? StAck : StWrReq;
      end
      StScCheck: state_d = sc_match ? StWrReq : StAck;
      StWrReq: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q[AddrWidth-1:3], 3'b000};
        mem_wdata_o = wdata;
        mem_be_o    = be;
        if (mem_gnt_i) state_d = StWrWait;
      end
      StWrWait: begin
        if (mem_rvalid_i) state_d = StAck;
      end
      StAck: begin
        amo_ack_o    = 1'b1;
        amo_result_o = result_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request latch, read-data capture and result formation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= OpNone;
      dbl_q    <= 1'b0;
      addr_q   <= '0;
      opb_q    <= '0;
      rdata_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= amo_op_i;
        dbl_q    <= amo_size_i[0];
        addr_q   <= amo_operand_a_i[AddrWidth-1:2];
        opb_q    <= amo_operand_b_i;
        result_q <= '0;
      end
      if (state_q == StRdWait && mem_rvalid_i) begin
        rdata_q  <= mem_rdata_i;
        result_q <= dbl_q ? mem_rdata_i : {{32{rd_half[31]}}, rd_half};
      end
      if (state_q == StScCheck) begin
        result_q <= sc_match ? '0 : {{(DataWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  // LR/SC reservation: set by LR data return, cleared by any SC or a write to the line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_line_q  <= '0;
      res_half_q  <= 1'b0;
      res_dbl_q   <= 1'b0;
    end else if (state_q == StRdWait && mem_rvalid_i && op_q == OpLr) begin
      res_valid_q <= 1'b1;
      res_line_q  <= addr_q[AddrWidth-1:3];
      res_half_q  <= addr_q[2];
      res_dbl_q   <= dbl_q;
    end else if (state_q == StScCheck) begin
      res_valid_q <= 1'b0;
    end else if (state_q == StWrWait && mem_rvalid_i &&
                 res_line_q == addr_q[AddrWidth-1:3]) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amo_responder.sv
// Randomised scoreboard bench for amo_responder with a behavioural memory and
// an LR/SC reference model.
module tb_amo_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        amo_req_i = 1'b0;
  logic [3:0]  amo_op_i = '0;
  logic [1:0]  amo_size_i = '0;
  logic [63:0] amo_operand_a_i = '0;
  logic [63:0] amo_operand_b_i = '0;
  logic        amo_ack_o;
  logic [63:0] amo_result_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;

  amo_responder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .amo_req_i       (amo_req_i),
    .amo_op_i        (amo_op_i),
    .amo_size_i      (amo_size_i),
    .amo_operand_a_i (amo_operand_a_i),
    .amo_operand_b_i (amo_operand_b_i),
    .amo_ack_o       (amo_ack_o),
    .amo_result_o    (amo_result_o),
    .mem_req_o       (mem_req_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_be_o        (mem_be_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0]     result;
    int              lat;       // -1: not checked
    int              rd;
    int              wr;
    longint unsigned line;
    logic [63:0]     mem_after;
    int              acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] bus_mem   [longint unsigned];
  logic [63:0] model_mem [longint unsigned];
  bit              m_rvalid = 0;
  longint unsigned m_rline  = 0;
  bit              m_rhi    = 0;
  bit              m_rdbl   = 0;

  bit gnt_en    = 0;
  bit zero_wait = 1;
  int stall_cnt = 0;
  int rd_cnt    = 0;
  int wr_cnt    = 0;

  assign mem_gnt_i = mem_req_o & gnt_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bus_rd(input longint unsigned line);
    return bus_mem.exists(line) ? bus_mem[line] : 64'h0;
  endfunction

  // Reference model: applies one request to the model memory/reservation and
  // returns the response, memory traffic and zero-wait latency it must produce.
  function automatic void model_op(input logic [3:0] op, input logic [1:0] size,
                                   input logic [63:0] addr, input logic [63:0] b,
                                   output exp_t e);
    logic [63:0]     cur, nv;
    longint unsigned line;
    bit              hi, dbl, legal;
    int unsigned     o32, b32, n32;
    int              so32, sb32;
    longint unsigned o64, b64, n64;
    longint          so64, sb64;
    line  = addr >> 3;
    hi    = addr[2];
    dbl   = (size == 2'b11);
    legal = (size == 2'b10 || size == 2'b11) && op >= 1 && op <= 11;
    cur   = model_mem.exists(line) ? model_mem[line] : 64'h0;
    nv    = cur;
    e.line = line; e.result = 0; e.rd = 0; e.wr = 0; e.lat = 1;
    e.mem_after = cur; e.acc_cyc = 0;
    if (!legal) begin
      e.lat = 1;
    end else if (op == 2) begin
      if (m_rvalid && m_rline == line && m_rhi == hi && m_rdbl == dbl) begin
        if (dbl)     nv = b;
        else if (hi) nv = {b[31:0], cur[31:0]};
        else         nv = {cur[63:32], b[31:0]};
        model_mem[line] = nv;
        e.mem_after = nv; e.wr = 1; e.lat = 4; e.result = 0;
      end else begin
        e.result = 1; e.lat = 2;
      end
      m_rvalid = 0;
    end else begin
      e.rd = 1;
      if (dbl) begin
        o64 = cur; b64 = b; so64 = o64; sb64 = b64;
        case (op)
          4:       n64 = o64 + b64;
          5:       n64 = o64 & b64;
          6:       n64 = o64 | b64;
          7:       n64 = o64 ^ b64;
          8:       n64 = (so64 > sb64) ? o64 : b64;
          9:       n64 = (o64 > b64) ? o64 : b64;
          10:      n64 = (so64 < sb64) ? o64 : b64;
          11:      n64 = (o64 < b64) ? o64 : b64;
          default: n64 = b64;
        endcase
        e.result = o64;
        nv = n64;
      end else begin
        o32 = hi ? cur[63:32] : cur[31:0];
        b32 = b[31:0]; so32 = o32; sb32 = b32;
        case (op)
          4:       n32 = o32 + b32;
          5:       n32 = o32 & b32;
          6:       n32 = o32 | b32;
          7:       n32 = o32 ^ b32;
          8:       n32 = (so32 > sb32) ? o32 : b32;
          9:       n32 = (o32 > b32) ? o32 : b32;
          10:      n32 = (so32 < sb32) ? o32 : b32;
          11:      n32 = (o32 < b32) ? o32 : b32;
          default: n32 = b32;
        endcase
        e.result = longint'(so32);
        nv = hi ? {n32, cur[31:0]} : {cur[63:32], n32};
      end
      if (op == 1) begin
        e.lat = 3;
        m_rvalid = 1; m_rline = line; m_rhi = hi; m_rdbl = dbl;
      end else begin
        e.wr = 1; e.lat = 5;
        model_mem[line] = nv;
        e.mem_after = nv;
        if (m_rvalid && m_rline == line) m_rvalid = 0;
      end
    end
  endfunction

  // Memory side: grant (optionally stalled), apply byte-enabled writes, return
  // rvalid one or more cycles later, and check that a stalled request holds still.
  initial begin : mem_proc
    bit          pend;
    logic        s_we;
    logic [63:0] s_addr, s_wdata, v;
    logic [7:0]  s_be;
    pend = 0;
    forever begin
      @(negedge clk_i);
      if (pend && mem_req_o && !rst_i) begin
        check("stall_addr", mem_addr_o, s_addr);
        check("stall_wdata", mem_wdata_o, s_wdata);
        check("stall_we_be", {55'b0, mem_we_o, mem_be_o}, {55'b0, s_we, s_be});
      end
      pend = 0;
      if (stall_cnt > 0) begin
        gnt_en = 0;
        if (mem_req_o) stall_cnt--;
      end else if (zero_wait) begin
        gnt_en = 1;
      end else begin
        gnt_en = ($urandom_range(0, 3) != 0);
      end
      s_we = mem_we_o; s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_be = mem_be_o;
      if (mem_req_o && gnt_en) begin
        @(posedge clk_i); #1;
        v = bus_rd(s_addr >> 3);
        if (s_we) begin
          for (int k = 0; k < 8; k++) if (s_be[k]) v[k*8 +: 8] = s_wdata[k*8 +: 8];
          bus_mem[s_addr >> 3] = v;
          wr_cnt++;
        end else begin
          rd_cnt++;
        end
        if (!zero_wait) begin
          repeat ($urandom_range(0, 2)) @(posedge clk_i);
          #1;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = s_we ? {$urandom, $urandom} : v;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
      end else if (mem_req_o) begin
        pend = 1;
      end
    end
  end

  // Monitor: every acknowledge is matched against the oldest expected response.
  always @(negedge clk_i) begin
    if (amo_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(amo_ack_o), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("result", amo_result_o, mon_e.result);
        check("mem_reads", 64'(rd_cnt), 64'(mon_e.rd));
        check("mem_writes", 64'(wr_cnt), 64'(mon_e.wr));
        check("mem_line", bus_rd(mon_e.line), mon_e.mem_after);
        if (mon_e.lat >= 0) check("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
      end
    end
  end

  task automatic poke(input longint unsigned addr, input logic [63:0] v);
    bus_mem[addr >> 3]   = v;
    model_mem[addr >> 3] = v;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [1:0] size, input logic [63:0] addr,
                       input logic [63:0] b, input int extra_lat, input bit chk_lat,
                       input bit scramble);
    exp_t e;
    bit   got;
    @(negedge clk_i);
    model_op(op, size, addr, b, e);
    e.acc_cyc = cyc;
    e.lat = chk_lat ? e.lat + extra_lat : -1;
    rd_cnt = 0;
    wr_cnt = 0;
    exp_q.push_back(e);
    amo_req_i = 1'b1; amo_op_i = op; amo_size_i = size;
    amo_operand_a_i = addr; amo_operand_b_i = b;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (amo_ack_o) begin
        got = 1;
        break;
      end
      if (scramble) begin
        amo_op_i = 4'($urandom); amo_size_i = 2'($urandom);
        amo_operand_a_i = {$urandom, $urandom}; amo_operand_b_i = {$urandom, $urandom};
      end
    end
    amo_req_i = 1'b0;
    amo_op_i  = '0;
    if (!got) begin
      check("ack_timeout", 64'(got), 64'(1));
      pulse_reset();
      exp_q.delete();
      m_rvalid = 0;
    end else begin
      @(negedge clk_i);
      check("ack_one_cycle", 64'(amo_ack_o), 64'(0));
    end
  endtask

  // Assert reset while the DUT waits for write completion, then check every
  // output dropped immediately.
  task automatic reset_in_wr_wait();
    exp_t e;
    bit   got;
    @(negedge clk_i);
    poke(64'h3000, 64'h1111_2222_3333_4444);
    rd_cnt = 0;
    wr_cnt = 0;
    amo_req_i = 1'b1; amo_op_i = 4'd3; amo_size_i = 2'b11;
    amo_operand_a_i = 64'h3000; amo_operand_b_i = 64'h5555_6666_7777_8888;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #2;
      if (wr_cnt != 0) begin
        got = 1;
        break;
      end
    end
    check("reached_wr_wait", 64'(got), 64'(1));
    rst_i = 1'b1;
    #1;
    check("rst_ack", 64'(amo_ack_o), 64'(0));
    check("rst_result", amo_result_o, 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_mem_we", 64'(mem_we_o), 64'(0));
    check("rst_mem_addr", mem_addr_o, 64'(0));
    check("rst_mem_wdata", mem_wdata_o, 64'(0));
    check("rst_mem_be", 64'(mem_be_o), 64'(0));
    amo_req_i = 1'b0;
    amo_op_i  = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_op(4'd3, 2'b11, 64'h3000, 64'h5555_6666_7777_8888, e);
    m_rvalid = 0;
  endtask

  initial begin : stim
    logic [3:0]  op;
    logic [1:0]  size;
    logic [63:0] addr, b;
    int          r;
    #1 rst_i = 1'b1;
    #2;
    check("reset_ack", 64'(amo_ack_o), 64'(0));
    check("reset_result", amo_result_o, 64'(0));
    check("reset_mem_req", 64'(mem_req_o), 64'(0));
    check("reset_mem_we", 64'(mem_we_o), 64'(0));
    check("reset_mem_addr", mem_addr_o, 64'(0));
    check("reset_mem_be", 64'(mem_be_o), 64'(0));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) poke(64'h3000 + 64'(i * 8), {$urandom, $urandom});

    zero_wait = 1;
    poke(64'h1000, 64'h0000_0000_0000_0005);
    do_op(4'd4, 2'b11, 64'h1000, 64'h3, 0, 1, 0);
    check("add_d_wdata", bus_rd(64'h1000 >> 3), 64'h8);

    poke(64'h2000, 64'hFFFF_FFFE_0000_0001);
    do_op(4'd8, 2'b10, 64'h2004, 64'h0000_0003, 0, 1, 0);
    check("max_w_hi_wdata", bus_rd(64'h2000 >> 3), 64'h0000_0003_0000_0001);

    poke(64'h2800, 64'h0000_0000_8000_0000);
    do_op(4'd11, 2'b10, 64'h2800, 64'h7FFF_FFFF, 0, 1, 0);
    check("minu_w_lo_wdata", bus_rd(64'h2800 >> 3), 64'h0000_0000_7FFF_FFFF);

    do_op(4'd1, 2'b11, 64'h3000, 64'h0, 0, 1, 0);
    do_op(4'd2, 2'b11, 64'h3000, 64'hAB, 0, 1, 0);
    check("sc_pass_wdata", bus_rd(64'h3000 >> 3), 64'hAB);
    do_op(4'd2, 2'b11, 64'h3000, 64'hCD, 0, 1, 0);

    do_op(4'd1, 2'b10, 64'h3000, 64'h0, 0, 1, 0);
    do_op(4'd3, 2'b11, 64'h3000, 64'hDEAD_BEEF_0BAD_F00D, 0, 1, 0);
    do_op(4'd2, 2'b10, 64'h3000, 64'h77, 0, 1, 0);

    do_op(4'd1, 2'b10, 64'h3004, 64'h0, 0, 1, 0);
    do_op(4'd2, 2'b10, 64'h3004, 64'h1234_5678, 0, 1, 0);

    do_op(4'd0, 2'b11, 64'h3008, 64'h99, 0, 1, 0);
    do_op(4'd4, 2'b01, 64'h3008, 64'h99, 0, 1, 0);

    stall_cnt = 4;
    do_op(4'd4, 2'b11, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1, 0);

    do_op(4'd1, 2'b11, 64'h3010, 64'h0, 0, 1, 0);
    reset_in_wr_wait();
    do_op(4'd2, 2'b11, 64'h3010, 64'h42, 0, 1, 0);
    do_op(4'd1, 2'b11, 64'h3000, 64'h0, 0, 1, 0);

    zero_wait = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 1)       op = 4'd0;
      else if (r < 5)  op = 4'd1;
      else if (r < 9)  op = 4'd2;
      else             op = 4'($urandom_range(3, 11));
      size = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 1))
                                          : ($urandom_range(0, 1) ? 2'b11 : 2'b10);
      addr = 64'h3000 + 64'($urandom_range(0, 3) * 8);
      if (size == 2'b10) addr[2] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       b = 64'h0000_0000_8000_0000;
        1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: b = {$urandom, $urandom};
      endcase
      do_op(op, size, addr, b, 0, 0, 1);
    end

    repeat (5) @(negedge clk_i);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
